ex_forward_ctrl: RTL
====================

EX_FORWARD_CTRL -- requirements
Module: ex_forward_ctrl

Interface
REQ-001 SHALL have port clk, input, 1, sole clock; all state updates on rising edge.
REQ-002 SHALL have port reset, input, 1, asynchronous active-low reset.
REQ-003 SHALL have ports id_rs, id_rt, input, 5 each, source register numbers of the instruction in ID.
REQ-004 SHALL have ports id_uses_rs, id_uses_rt, input, 1 each, set when the ID instruction reads that source.
REQ-005 SHALL have ports id_dest, input, 5, and id_reg_write, input, 1: ID instruction writes register id_dest.
REQ-006 SHALL have ports id_mem_read, input, 1, set for loads; id_valid, input, 1, set when ID holds a real instruction.
REQ-007 SHALL have port flush, input, 1, which kills the ID instruction (branch taken).
REQ-008 SHALL have ports Forward_A, Forward_B, output, 2 each, registered EX-stage forwarding selects.
REQ-009 SHALL have port stall, output, 1, combinational; holds PC and IF/ID.
REQ-010 SHALL have ports stall_count and fwd_count, output, 16 each, saturating event counters.

Function
REQ-011 SHALL encode selects as 00 = register file value, 01 = MEM/WB write-back result, 10 = EX/MEM ALU result; 11 is never driven.
REQ-012 SHALL keep three shadow slots {dest, wr, load}: EXs (mirrors ID/EX), MEMs (EX/MEM), WBs (MEM/WB).
REQ-013 SHALL shift every cycle: WBs <= MEMs, MEMs <= EXs.
REQ-014 SHALL load EXs <= {id_dest, id_reg_write & id_valid, id_mem_read & id_valid} when stall=0 and flush=0, else load a bubble (wr=0, load=0).
REQ-015 SHALL assert stall = id_valid & !flush & EXs.load & EXs.wr & EXs.dest!=0 & ((id_uses_rs & id_rs==EXs.dest) | (id_uses_rt & id_rt==EXs.dest)).
REQ-016 SHALL register Forward_A next = 10 if id_uses_rs & EXs.wr & EXs.dest==id_rs & id_rs!=0; else 01 if id_uses_rs & MEMs.wr & MEMs.dest==id_rs & id_rs!=0; else 00.
REQ-017 SHALL register Forward_B identically using id_rt / id_uses_rt.
REQ-018 SHALL give EXs match priority over MEMs match (youngest writer wins).
REQ-019 SHALL register Forward_A/B = 00 when stall=1, flush=1 or id_valid=0.
REQ-020 SHALL never forward from WBs; the register file is write-first, so the MEM/WB writer is already visible to ID.
REQ-021 SHALL give Forward_A/B a one-cycle latency: values computed in ID are valid the cycle the instruction sits in ID/EX.
REQ-022 SHALL increment stall_count on each cycle with stall=1, and fwd_count on each cycle where registered Forward_A or Forward_B becomes nonzero (by 1, not 2), both saturating at 16'hFFFF.
REQ-023 SHALL let flush override stall: flush=1 forces stall=0 and an EXs bubble.

Reset
REQ-024 SHALL, while reset=0, asynchronously clear all slots (wr=0, load=0, dest=0), Forward_A=Forward_B=00, counters=0; stall therefore reads 0.
REQ-025 SHALL resume normal shifting on the first rising edge after reset deasserts; reset mid-stall discards the hazard.

Structure
REQ-026 SHALL place select encodings (FWD_RF, FWD_WB, FWD_EXMEM) and the slot record type in a shared pipeline package used also by the EX stage.
REQ-027 SHALL use one sub-module, fwd_compare, instantiated twice (rs, rt) to produce select and load-use match.

Verification
REQ-028 SHALL cover: add $3 then sub $4,$3,$5 back-to-back -> Forward_A=10 during sub's EX cycle, stall_count=0.
REQ-029 SHALL cover: add $3, nop, or $6,$5,$3 -> Forward_B=01 for or; with intervening add $3 again -> Forward_B=10.
REQ-030 SHALL cover: lw $2 then add $7,$2,$2 -> stall=1 exactly one cycle, bubble inserted, then Forward_A=Forward_B=01, stall_count=1.
REQ-031 SHALL cover: writer to $0 followed by reader of $0 -> Forward_A=Forward_B=00.
REQ-032 SHALL cover: lw $2 with dependent add in ID and flush=1 same cycle -> stall=0, EXs bubble, Forward=00.
REQ-033 SHALL cover: reset asserted during a stall -> all outputs 0 immediately; 65540 forced stall cycles -> stall_count=16'hFFFF.

Source files
------------

// File: rtl/ex_forward_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// ex_forward_ctrl_pkg
//   Pipeline definitions shared by the forwarding/hazard control and the
//   EX stage datapath.
//   - FWD_*      : EX operand mux select encodings
//   - slot_t     : shadow record of one pipeline register {dest, wr, load}
//   - sat_inc16  : saturating 16-bit event counter step
// ---------------------------------------------------------------------------
package ex_forward_ctrl_pkg;

   localparam int REG_W = 5;

   // EX operand mux selects; 2'b11 is unused and never produced
   localparam logic [1:0] FWD_RF    = 2'b00;  // register file read value
   localparam logic [1:0] FWD_WB    = 2'b01;  // MEM/WB write-back result
   localparam logic [1:0] FWD_EXMEM = 2'b10;  // EX/MEM ALU result

   typedef struct packed {
      logic [REG_W-1:0] dest;
      logic             wr;
      logic             load;
   } slot_t;

   localparam slot_t SLOT_BUBBLE = '0;

   function automatic logic [15:0] sat_inc16(input logic [15:0] v, input logic en);
      return (en && (v != 16'hFFFF)) ? v + 16'd1 : v;
   endfunction

endpackage

// File: rtl/ex_forward_ctrl_fwd_compare.sv
// ---------------------------------------------------------------------------
// fwd_compare
//   Compares one ID source register against the EX and MEM shadow slots.
//   Ports:
//     i_src, i_uses          : source register number and "is read" flag
//     i_ex_dest/wr/load      : EX shadow slot (instruction now in ID/EX)
//     i_mem_dest/wr          : MEM shadow slot (instruction now in EX/MEM)
//     o_sel                  : forwarding select for this operand
//     o_load_use             : source depends on a load still in EX
// ---------------------------------------------------------------------------
module fwd_compare
   import ex_forward_ctrl_pkg::*;
(
   input  logic [REG_W-1:0] i_src,
   input  logic             i_uses,
   input  logic [REG_W-1:0] i_ex_dest,
   input  logic             i_ex_wr,
   input  logic             i_ex_load,
   input  logic [REG_W-1:0] i_mem_dest,
   input  logic             i_mem_wr,
   output logic [1:0]       o_sel,
   output logic             o_load_use
);

   logic w_live;
   logic w_ex_hit;
   logic w_mem_hit;

   // $0 is hard-wired zero: never forward it, never stall on it
   assign w_live    = i_uses & (i_src != '0);
   assign w_ex_hit  = w_live & i_ex_wr  & (i_ex_dest  == i_src);
   assign w_mem_hit = w_live & i_mem_wr & (i_mem_dest == i_src);

   // youngest writer wins
   always_comb begin
      o_sel = FWD_RF;
      if (w_ex_hit)       o_sel = FWD_EXMEM;
      else if (w_mem_hit) o_sel = FWD_WB;
   end

   // a load in EX has no data until MEM completes, so it cannot be forwarded
   assign o_load_use = w_ex_hit & i_ex_load;

endmodule

// File: rtl/ex_forward_ctrl.sv
// ---------------------------------------------------------------------------
// ex_forward_ctrl
//   Forwarding and load-use hazard control for a 5-stage pipeline. Tracks
//   the destination of the three younger pipeline registers in shadow slots
//   and, for the instruction in ID, computes the EX operand selects that
//   take effect the cycle it occupies ID/EX.
//   Ports:
//     clk, reset                : clock, async active-low reset
//     id_rs, id_rt              : ID source registers
//     id_uses_rs, id_uses_rt    : ID instruction reads rs / rt
//     id_dest, id_reg_write     : ID destination and write enable
//     id_mem_read, id_valid     : ID is a load / ID holds a real instruction
//     flush                     : kill the ID instruction (taken branch)
//     Forward_A, Forward_B      : registered EX operand selects
//     stall                     : combinational, holds PC and IF/ID
//     stall_count, fwd_count    : saturating event counters
// ---------------------------------------------------------------------------
module ex_forward_ctrl
   import ex_forward_ctrl_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic [4:0]  id_rs,
   input  logic [4:0]  id_rt,
   input  logic        id_uses_rs,
   input  logic        id_uses_rt,
   input  logic [4:0]  id_dest,
   input  logic        id_reg_write,
   input  logic        id_mem_read,
   input  logic        id_valid,
   input  logic        flush,
   output logic [1:0]  Forward_A,
   output logic [1:0]  Forward_B,
   output logic        stall,
   output logic [15:0] stall_count,
   output logic [15:0] fwd_count
);

   slot_t       r_exs;    // mirrors ID/EX
   slot_t       r_mems;   // mirrors EX/MEM
   slot_t       r_wbs;    // mirrors MEM/WB
   logic [1:0]  r_fwd_a;
   logic [1:0]  r_fwd_b;
   logic [15:0] r_stall_cnt;
   logic [15:0] r_fwd_cnt;

   logic [1:0]  w_sel_a;
   logic [1:0]  w_sel_b;
   logic        w_lu_a;
   logic        w_lu_b;
   logic        w_stall;
   logic        w_kill;
   logic [1:0]  w_fa_nxt;
   logic [1:0]  w_fb_nxt;
   logic        w_fwd_evt;
   slot_t       w_exs_nxt;

   fwd_compare u_cmp_rs (
      .i_src      (id_rs),
      .i_uses     (id_uses_rs),
      .i_ex_dest  (r_exs.dest),
      .i_ex_wr    (r_exs.wr),
      .i_ex_load  (r_exs.load),
      .i_mem_dest (r_mems.dest),
      .i_mem_wr   (r_mems.wr),
      .o_sel      (w_sel_a),
      .o_load_use (w_lu_a)
   );

   fwd_compare u_cmp_rt (
      .i_src      (id_rt),
      .i_uses     (id_uses_rt),
      .i_ex_dest  (r_exs.dest),
      .i_ex_wr    (r_exs.wr),
      .i_ex_load  (r_exs.load),
      .i_mem_dest (r_mems.dest),
      .i_mem_wr   (r_mems.wr),
      .o_sel      (w_sel_b),
      .o_load_use (w_lu_b)
   );

   // flush wins over stall: a killed instruction has no hazard to resolve
   assign w_stall = id_valid & ~flush & (w_lu_a | w_lu_b);
   assign stall   = w_stall;

   // anything that does not advance into ID/EX as a real instruction gets
   // register-file selects
   assign w_kill   = w_stall | flush | ~id_valid;
   assign w_fa_nxt = w_kill ? FWD_RF : w_sel_a;
   assign w_fb_nxt = w_kill ? FWD_RF : w_sel_b;

   // one event per cycle even when both operands forward
   assign w_fwd_evt = (w_fa_nxt != FWD_RF) | (w_fb_nxt != FWD_RF);

   always_comb begin
      w_exs_nxt = SLOT_BUBBLE;
      if (!w_stall && !flush) begin
         w_exs_nxt.dest = id_dest;
         w_exs_nxt.wr   = id_reg_write & id_valid;
         w_exs_nxt.load = id_mem_read  & id_valid;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_exs       <= SLOT_BUBBLE;
         r_mems      <= SLOT_BUBBLE;
         r_wbs       <= SLOT_BUBBLE;
         r_fwd_a     <= FWD_RF;
         r_fwd_b     <= FWD_RF;
         r_stall_cnt <= '0;
         r_fwd_cnt   <= '0;
      end else begin
         r_wbs       <= r_mems;
         r_mems      <= r_exs;
         r_exs       <= w_exs_nxt;
         r_fwd_a     <= w_fa_nxt;
         r_fwd_b     <= w_fb_nxt;
         r_stall_cnt <= sat_inc16(r_stall_cnt, w_stall);
         r_fwd_cnt   <= sat_inc16(r_fwd_cnt, w_fwd_evt);
      end
   end

   // The WB slot is tracked for completeness but never forwarded from: the
   // register file is write-first, so ID already sees the MEM/WB writer.
   // Keep it honestly tied to the MEM slot history.
   a_wbs_tracks_mems : assert property (@(posedge clk) disable iff (!reset)
      r_wbs == $past(r_mems));

   assign Forward_A   = r_fwd_a;
   assign Forward_B   = r_fwd_b;
   assign stall_count = r_stall_cnt;
   assign fwd_count   = r_fwd_cnt;

endmodule
